// File: rtl/split_two_outputs.sv
// Stream splitter: pops one show-ahead FIFO and writes aligned pairs to two output FIFOs.
// BROADCAST=0 deinterleaves even/odd samples to A/B, BROADCAST=1 duplicates each sample.
module split_two_outputs #(
  parameter int DATA_WIDTH = 32,
  parameter bit BROADCAST  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  outA_wr_en,
  input  logic                  outA_full,
  output logic [DATA_WIDTH-1:0] outA_din,
  output logic                  outB_wr_en,
  input  logic                  outB_full,
  output logic [DATA_WIDTH-1:0] outB_din
);

  typedef enum logic [1:0] {
    S_FIRST  = 2'd0,
    S_SECOND = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   reg_a_q, reg_a_d;
  logic [DATA_WIDTH-1:0]   reg_b_q, reg_b_d;
  logic                    wr_ok;
  logic                    rd_en;

  always_comb begin
    state_d = state_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    wr_ok   = (state_q == S_WRITE) && !outA_full && !outB_full && !reset;
    rd_en   = 1'b0;

    case (state_q)
      S_FIRST, S_SECOND: rd_en = !in_empty;
      S_WRITE:           rd_en = wr_ok && !in_empty;
      default:           rd_en = 1'b0;
    endcase
    if (reset) rd_en = 1'b0;

    // rd_en already implies !in_empty, so it is the pop qualifier.
    case (state_q)
      S_FIRST: begin
        if (rd_en) begin
          reg_a_d = in_dout;
          if (BROADCAST) begin
            reg_b_d = in_dout;
            state_d = S_WRITE;
          end else begin
            state_d = S_SECOND;
          end
        end
      end
      S_SECOND: begin
        if (rd_en) begin
          reg_b_d = in_dout;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ok) begin
          if (rd_en) begin
            reg_a_d = in_dout;
            if (BROADCAST) begin
              reg_b_d = in_dout;
              state_d = S_WRITE;
            end else begin
              state_d = S_SECOND;
            end
          end else begin
            state_d = S_FIRST;
          end
        end
      end
      default: state_d = S_FIRST;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FIRST;
      reg_a_q <= '0;
      reg_b_q <= '0;
    end else begin
      state_q <= state_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
    end
  end

  assign in_rd_en   = rd_en;
  assign outA_wr_en = wr_ok;
  assign outB_wr_en = wr_ok;
  assign outA_din   = reg_a_q;
  assign outB_din   = reg_b_q;

endmodule

// File: tb/tb_split_two_outputs.sv
// Scoreboard bench for split_two_outputs: one deinterleave instance and one broadcast instance.
module tb_split_two_outputs;

  logic        clock = 1'b0;
  logic        reset;
  always #5 clock = ~clock;

  logic        rd0, empty0, wa0, fa0, wb0, fb0, gap0;
  logic [31:0] dout0, da0, db0;
  logic        rd1, empty1, wa1, fa1, wb1, fb1;
  logic [31:0] dout1, da1, db1;

  logic signed [31:0] src0[$];
  logic signed [31:0] src1[$];
  logic [63:0]        exp0[$];
  logic [63:0]        exp1[$];
  int                 pop_log0[$], wr_log0[$], pop_log1[$], wr_log1[$];
  int                 cyc = 0;
  int                 n_checks = 0;
  int                 n_errors = 0;

  split_two_outputs #(.DATA_WIDTH(32), .BROADCAST(1'b0)) dut0 (
    .clock(clock), .reset(reset),
    .in_rd_en(rd0), .in_empty(empty0), .in_dout(dout0),
    .outA_wr_en(wa0), .outA_full(fa0), .outA_din(da0),
    .outB_wr_en(wb0), .outB_full(fb0), .outB_din(db0)
  );

  split_two_outputs #(.DATA_WIDTH(32), .BROADCAST(1'b1)) dut1 (
    .clock(clock), .reset(reset),
    .in_rd_en(rd1), .in_empty(empty1), .in_dout(dout1),
    .outA_wr_en(wa1), .outA_full(fa1), .outA_din(da1),
    .outB_wr_en(wb1), .outB_full(fb1), .outB_din(db1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  // Input FIFO models: pop decided at the edge, contents refreshed after stimulus settles.
  initial begin
    bit p0, p1;
    empty0 = 1'b1; dout0 = '0;
    empty1 = 1'b1; dout1 = '0;
    forever begin
      @(posedge clock);
      p0 = rd0 && !empty0;
      p1 = rd1 && !empty1;
      #1;
      if (p0) void'(src0.pop_front());
      if (p1) void'(src1.pop_front());
      #2;
      empty0 = gap0 || (src0.size() == 0);
      dout0  = (src0.size() > 0) ? src0[0] : '0;
      empty1 = (src1.size() == 0);
      dout1  = (src1.size() > 0) ? src1[0] : '0;
    end
  end

  // Output monitor: every write strobe pops and compares one expected pair.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        if (rd0 && !empty0) pop_log0.push_back(cyc);
        if (rd1 && !empty1) pop_log1.push_back(cyc);
        if (wa0 !== wb0) check("strobe_split0", 64'(wb0), 64'(wa0));
        if (wa1 !== wb1) check("strobe_split1", 64'(wb1), 64'(wa1));
        if (wa0) begin
          wr_log0.push_back(cyc);
          if (exp0.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_write0: got %h expected no write", {da0, db0});
          end else check("pair0", {da0, db0}, exp0.pop_front());
        end
        if (wa1) begin
          wr_log1.push_back(cyc);
          if (exp1.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_write1: got %h expected no write", {da1, db1});
          end else check("pair1", {da1, db1}, exp1.pop_front());
        end
      end
    end
  end

  task automatic push_pair0(input logic signed [31:0] a, input logic signed [31:0] b);
    src0.push_back(a);
    src0.push_back(b);
    exp0.push_back({a, b});
  endtask

  task automatic push_bc1(input logic signed [31:0] v);
    src1.push_back(v);
    exp1.push_back({v, v});
  endtask

  task automatic drain(input int sel, input string name);
    int n = 0;
    while (((sel == 0) ? exp0.size() : exp1.size()) != 0 && n < 300) begin
      tick();
      n++;
    end
    if (((sel == 0) ? exp0.size() : exp1.size()) != 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout: got %0d pairs outstanding expected 0", name,
               (sel == 0) ? exp0.size() : exp1.size());
      if (sel == 0) exp0.delete(); else exp1.delete();
    end
    tick(3);
  endtask

  initial begin
    int b0p, b0w, b1p, b1w, sp, sw, n;
    logic signed [31:0] v;

    reset = 1'b1; gap0 = 1'b0;
    fa0 = 1'b0; fb0 = 1'b0; fa1 = 1'b0; fb1 = 1'b0;
    tick(2);
    push_bc1(7);
    push_bc1(-8);
    push_bc1(32'sh7fffffff);
    push_bc1(32'sh80000000);
    tick();
    @(negedge clock);
    check("reset_rd_en", 64'(rd1), 64'd0);
    check("reset_wr_en", 64'({wa1, wb1}), 64'd0);
    check("reset_regs", {da0, db0}, 64'd0);

    // Mode 0 streaming and mode 1 broadcast run side by side.
    tick();
    reset = 1'b0;
    b0p = pop_log0.size(); b0w = wr_log0.size();
    b1p = pop_log1.size(); b1w = wr_log1.size();
    push_pair0(1, -2);
    push_pair0(3, -4);
    push_pair0(5, -6);
    drain(0, "stream0");
    drain(1, "bcast1");

    check("t1_pops", 64'(pop_log0.size() - b0p), 64'd6);
    check("t1_writes", 64'(wr_log0.size() - b0w), 64'd3);
    if (pop_log0.size() - b0p == 6 && wr_log0.size() - b0w == 3) begin
      check("t1_pop_span", 64'(pop_log0[b0p+5] - pop_log0[b0p]), 64'd5);
      check("t1_latency", 64'(wr_log0[b0w] - pop_log0[b0p]), 64'd2);
      check("t1_wr_gap_a", 64'(wr_log0[b0w+1] - wr_log0[b0w]), 64'd2);
      check("t1_wr_gap_b", 64'(wr_log0[b0w+2] - wr_log0[b0w+1]), 64'd2);
    end
    check("t2_pops", 64'(pop_log1.size() - b1p), 64'd4);
    check("t2_writes", 64'(wr_log1.size() - b1w), 64'd4);
    if (pop_log1.size() - b1p == 4 && wr_log1.size() - b1w == 4) begin
      check("t2_latency", 64'(wr_log1[b1w] - pop_log1[b1p]), 64'd1);
      check("t2_wr_span", 64'(wr_log1[b1w+3] - wr_log1[b1w]), 64'd3);
    end

    // B full while the first pair is ready: no writes, no pops.
    fb0 = 1'b1;
    push_pair0(10, 20);
    push_pair0(30, 40);
    tick(2);
    sp = pop_log0.size(); sw = wr_log0.size();
    tick(10);
    check("stall_pops", 64'(pop_log0.size() - sp), 64'd0);
    check("stall_writes", 64'(wr_log0.size() - sw), 64'd0);
    check("stall_hold", {da0, db0}, {32'd10, 32'd20});
    fb0 = 1'b0;
    drain(0, "stall0");

    // Lone sample held across an empty gap.
    src0.push_back(5);
    tick();
    sw = wr_log0.size();
    tick(20);
    check("gap_writes", 64'(wr_log0.size() - sw), 64'd0);
    check("gap_hold_a", 64'(da0), 64'd5);
    src0.push_back(6);
    exp0.push_back({32'sd5, 32'sd6});
    drain(0, "gap0");

    // Reset with a half pair pending.
    src0.push_back(99);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("midreset_regs", {da0, db0}, 64'd0);
    push_pair0(11, 12);
    drain(0, "midreset0");

    // Random samples with random empty and full gaps.
    for (int i = 0; i < 500; i++) begin
      push_pair0($urandom, $urandom);
    end
    n = 0;
    while ((exp0.size() != 0) && n < 8000) begin
      gap0 = ($urandom_range(0, 3) == 0);
      fa0  = ($urandom_range(0, 4) == 0);
      fb0  = ($urandom_range(0, 4) == 0);
      tick();
      n++;
    end
    gap0 = 1'b0; fa0 = 1'b0; fb0 = 1'b0;
    drain(0, "random0");
    check("random_src_left", 64'(src0.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
